// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, R/W bit value and pointer width helper.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WACK,
        ST_RDATA,
        ST_RACK,
        ST_WAIT
    } i2c_state_t;

    localparam logic I2C_RW_READ = 1'b1;

    function automatic int ptr_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2c_slave_regs_if.sv
// User-side view of the register bank: register image, write strobe/index and busy.
interface i2c_slave_regs_if #(
    parameter int NUM_REGS = 16,
    parameter int PTR_W    = i2c_pkg::ptr_width(NUM_REGS)
);
    logic [NUM_REGS*8-1:0] regs_out;
    logic                  wr_stb;
    logic [PTR_W-1:0]      wr_ptr;
    logic                  busy;

    modport slave  (output regs_out, wr_stb, wr_ptr, busy);
    modport master (input  regs_out, wr_stb, wr_ptr, busy);
endinterface

// File: rtl/i2c_bus_sync.sv
// Oversamples SCL/SDA into clk and produces single-cycle edge, START and STOP pulses.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);
    logic [SYNC_STAGES-1:0] scl_ff;
    logic [SYNC_STAGES-1:0] sda_ff;
    logic                   scl_s;
    logic                   scl_h;
    logic                   sda_h;

    // Idle bus is high, so every flop resets to 1 to avoid a false START after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_ff <= '1;
            sda_ff <= '1;
            scl_h  <= 1'b1;
            sda_h  <= 1'b1;
        end else begin
            scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl};
            sda_ff <= {sda_ff[SYNC_STAGES-2:0], sda};
            scl_h  <= scl_s;
            sda_h  <= sda_s;
        end
    end

    assign scl_s    = scl_ff[SYNC_STAGES-1];
    assign sda_s    = sda_ff[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_h;
    assign scl_fall = ~scl_s & scl_h;
    assign start    = scl_s & scl_h & sda_h & ~sda_s;
    assign stop     = scl_s & scl_h & ~sda_h & sda_s;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C slave exposing NUM_REGS 8-bit registers with pointer byte, burst auto-increment and repeated START.
//   state       | meaning
//   ST_IDLE     | bus free, waiting for START
//   ST_ADDR     | shifting in 7-bit address + R/W
//   ST_ADDR_ACK | ACK slot for the address byte
//   ST_PTR      | shifting in the register pointer
//   ST_PTR_ACK  | ACK/NACK slot for the pointer byte
//   ST_WDATA    | shifting in a write data byte
//   ST_WACK     | ACK slot after a committed write byte
//   ST_RDATA    | shifting out regs[pointer]
//   ST_RACK     | sampling master ACK/NACK after a read byte
//   ST_WAIT     | not addressed / NACKed, ignore bits until START or STOP
module i2c_slave_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR        = 7'h77,
    parameter int         NUM_REGS    = 16,
    parameter logic [7:0] REG_INIT    = 8'hAA,
    parameter int         SYNC_STAGES = 2,
    localparam int        PTR_W       = ptr_width(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            scl,
    inout  wire             sda,
    i2c_slave_regs_if.slave user
);
    i2c_state_t       state, state_nxt;
    logic [2:0]       bitcnt, bitcnt_nxt;
    logic [7:0]       shreg, shreg_nxt, shift_in;
    logic [PTR_W-1:0] ptr, ptr_nxt, ptr_inc;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic             sda_oe, sda_oe_nxt;
    logic             busy, busy_nxt;
    logic             wr_stb, wr_stb_nxt;
    logic             reg_we;
    logic [7:0]       regs [NUM_REGS];
    logic             sda_s, scl_rise, scl_fall, start, stop;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl),
        .sda      (sda),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    assign shift_in = {shreg[6:0], sda_s};
    assign ptr_inc  = (ptr == PTR_W'(NUM_REGS - 1)) ? '0 : ptr + PTR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            bitcnt <= '0;
            shreg  <= '0;
            ptr    <= '0;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
            wr_stb <= 1'b0;
            wr_ptr <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= REG_INIT;
        end else begin
            state  <= state_nxt;
            bitcnt <= bitcnt_nxt;
            shreg  <= shreg_nxt;
            ptr    <= ptr_nxt;
            sda_oe <= sda_oe_nxt;
            busy   <= busy_nxt;
            wr_stb <= wr_stb_nxt;
            wr_ptr <= wr_ptr_nxt;
            if (reg_we) regs[ptr] <= shift_in;
        end
    end

    // ACK states leave on the rise after the ACK was driven; sda_oe marks that the ACK is on the bus.
    always_comb begin
        state_nxt  = state;
        bitcnt_nxt = bitcnt;
        shreg_nxt  = shreg;
        ptr_nxt    = ptr;
        sda_oe_nxt = sda_oe;
        busy_nxt   = busy;
        wr_stb_nxt = 1'b0;
        wr_ptr_nxt = wr_ptr;
        reg_we     = 1'b0;
        if (start) begin
            state_nxt  = ST_ADDR;
            bitcnt_nxt = '0;
            sda_oe_nxt = 1'b0;
            busy_nxt   = 1'b0;
        end else if (stop) begin
            state_nxt  = ST_IDLE;
            sda_oe_nxt = 1'b0;
            busy_nxt   = 1'b0;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_ADDR, ST_PTR: begin
                    if (scl_fall) begin
                        sda_oe_nxt = 1'b0;
                    end else if (scl_rise) begin
                        shreg_nxt  = shift_in;
                        bitcnt_nxt = bitcnt + 3'd1;
                        if (bitcnt == 3'd7) state_nxt = (state == ST_ADDR) ? ST_ADDR_ACK : ST_PTR_ACK;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (shreg[7:1] == ADDR) begin
                            sda_oe_nxt = 1'b1;
                            busy_nxt   = 1'b1;
                        end else begin
                            state_nxt = ST_WAIT;
                        end
                    end else if (scl_rise && sda_oe) begin
                        if (shreg[0] == I2C_RW_READ) begin
                            state_nxt = ST_RDATA;
                            shreg_nxt = regs[ptr];
                        end else begin
                            state_nxt = ST_PTR;
                        end
                    end
                end
                ST_PTR_ACK: begin
                    if (scl_fall) begin
                        if ({1'b0, shreg} < 9'(NUM_REGS)) begin
                            ptr_nxt    = shreg[PTR_W-1:0];
                            sda_oe_nxt = 1'b1;
                        end else begin
                            state_nxt = ST_WAIT;
                        end
                    end else if (scl_rise && sda_oe) begin
                        state_nxt = ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (scl_fall) begin
                        sda_oe_nxt = 1'b0;
                    end else if (scl_rise) begin
                        shreg_nxt  = shift_in;
                        bitcnt_nxt = bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            reg_we     = 1'b1;
                            wr_stb_nxt = 1'b1;
                            wr_ptr_nxt = ptr;
                            state_nxt  = ST_WACK;
                        end
                    end
                end
                ST_WACK: begin
                    if (scl_fall) begin
                        sda_oe_nxt = 1'b1;
                        ptr_nxt    = ptr_inc;
                    end else if (scl_rise && sda_oe) begin
                        state_nxt = ST_WDATA;
                    end
                end
                ST_RDATA: begin
                    if (scl_fall) begin
                        sda_oe_nxt = ~shreg[7];
                        shreg_nxt  = {shreg[6:0], 1'b0};
                    end else if (scl_rise) begin
                        bitcnt_nxt = bitcnt + 3'd1;
                        if (bitcnt == 3'd7) state_nxt = ST_RACK;
                    end
                end
                ST_RACK: begin
                    if (scl_fall) begin
                        sda_oe_nxt = 1'b0;
                    end else if (scl_rise) begin
                        ptr_nxt = ptr_inc;
                        if (sda_s == 1'b0) begin
                            shreg_nxt = regs[ptr_inc];
                            state_nxt = ST_RDATA;
                        end else begin
                            state_nxt = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: sda_oe_nxt = 1'b0;
                default: begin
                    state_nxt  = ST_IDLE;
                    sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    assign sda         = sda_oe ? 1'b0 : 1'bz;
    assign user.busy   = busy;
    assign user.wr_stb = wr_stb;
    assign user.wr_ptr = wr_ptr;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
        assign user.regs_out[8*k +: 8] = regs[k];
    end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bit-level I2C master, transaction-level register model, per-cycle compare.
module tb_i2c_slave_regs;
    import i2c_pkg::*;

    localparam int         NUM_REGS = 16;
    localparam int         PTR_W    = 4;
    localparam logic [6:0] ADDR     = 7'h77;
    localparam logic [7:0] REG_INIT = 8'hAA;
    localparam int         Q        = 6;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic scl   = 1'b1;
    logic m_low = 1'b0;
    wire  sda;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave_regs_if #(.NUM_REGS(NUM_REGS), .PTR_W(PTR_W)) user ();

    i2c_slave_regs #(
        .ADDR(ADDR), .NUM_REGS(NUM_REGS), .REG_INIT(REG_INIT), .SYNC_STAGES(2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .scl  (scl),
        .sda  (sda),
        .user (user)
    );

    always #5 clk = ~clk;

    typedef struct { int ptr; logic [7:0] data; } wr_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         stb_cnt  = 0;
    int         m_ptr    = 0;
    logic [7:0] m_regs [NUM_REGS];
    wr_t        exp_q [$];
    logic [7:0] wbuf [4];
    logic [7:0] rbuf [4];
    logic       last_addr_ack, last_ptr_ack, last_data_ack;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model image tracks committed bytes; each strobe must match the oldest byte the master sent.
    always @(negedge clk) begin
        wr_t                   e;
        logic [NUM_REGS*8-1:0] img;
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) m_regs[k] = REG_INIT;
            exp_q.delete();
        end else begin
            if (user.wr_stb) begin
                stb_cnt++;
                chk("wr_stb_expected", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("wr_ptr", 128'(user.wr_ptr), 128'(e.ptr));
                    m_regs[e.ptr] = e.data;
                end
            end
            for (int k = 0; k < NUM_REGS; k++) img[8*k +: 8] = m_regs[k];
            chk("regs_out", 128'(user.regs_out), 128'(img));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        tick(Q); m_low = ~b; tick(Q); scl = 1'b1; tick(2*Q); scl = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        tick(Q); m_low = 1'b0; tick(Q); scl = 1'b1; tick(Q); b = sda; tick(Q); scl = 1'b0;
    endtask

    task automatic i2c_start();
        m_low = 1'b0; tick(Q); scl = 1'b1; tick(Q); m_low = 1'b1; tick(Q); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        tick(Q); m_low = 1'b1; tick(Q); scl = 1'b1; tick(Q); m_low = 1'b0; tick(2*Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(a);
        ack = ~a;
    endtask

    task automatic recv_byte(input logic give_ack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) recv_bit(b[i]);
        send_bit(~give_ack);
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] p, input int n, input bit do_stop);
        logic ack;
        bit   hit, ptr_ok;
        hit = (a == ADDR);
        i2c_start();
        send_byte({a, 1'b0}, ack);
        last_addr_ack = ack;
        chk("addr_ack_w", 128'(ack), 128'(hit));
        chk("busy_after_addr", 128'(user.busy), 128'(hit));
        ptr_ok = hit && (int'(p) < NUM_REGS);
        send_byte(p, ack);
        last_ptr_ack = ack;
        chk("ptr_ack", 128'(ack), 128'(ptr_ok));
        if (ptr_ok) m_ptr = int'(p);
        for (int i = 0; i < n; i++) begin
            if (ptr_ok) begin
                exp_q.push_back('{m_ptr, wbuf[i]});
                m_ptr = (m_ptr + 1) % NUM_REGS;
            end
            send_byte(wbuf[i], ack);
            last_data_ack = ack;
            chk("data_ack", 128'(ack), 128'(ptr_ok));
            chk("wr_commit_pending", 128'(exp_q.size()), 128'(0));
        end
        if (do_stop) begin
            i2c_stop();
            chk("busy_after_stop", 128'(user.busy), 128'(0));
            chk("sda_after_stop", 128'(sda), 128'(1));
        end
    endtask

    task automatic do_read(input logic [6:0] a, input int n, input bit do_stop);
        logic       ack;
        logic [7:0] b;
        bit         hit;
        hit = (a == ADDR);
        i2c_start();
        send_byte({a, 1'b1}, ack);
        last_addr_ack = ack;
        chk("addr_ack_r", 128'(ack), 128'(hit));
        for (int i = 0; i < n; i++) begin
            recv_byte(i != n - 1, b);
            rbuf[i] = b;
            chk("read_data", 128'(b), 128'(hit ? m_regs[m_ptr] : 8'hFF));
            if (hit) m_ptr = (m_ptr + 1) % NUM_REGS;
        end
        tick(2);
        chk("sda_after_nack", 128'(sda), 128'(1));
        if (do_stop) begin
            i2c_stop();
            chk("busy_after_stop", 128'(user.busy), 128'(0));
        end
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] all_init;
        logic [6:0]   ra;
        logic [7:0]   rp;
        int           rn, kind, stb0;
        all_init = {NUM_REGS{REG_INIT}};

        tick(5);
        rst = 1'b0;
        tick(3);
        chk("rst_regs_out", 128'(user.regs_out), all_init);
        chk("rst_busy", 128'(user.busy), 128'(0));
        chk("rst_wr_stb", 128'(user.wr_stb), 128'(0));
        chk("rst_wr_ptr", 128'(user.wr_ptr), 128'(0));
        chk("rst_sda", 128'(sda), 128'(1));

        for (int i = 0; i < 30; i++) begin
            scl = ~scl;
            tick($urandom_range(2, 10));
            chk("idle_busy", 128'(user.busy), 128'(0));
            chk("idle_sda", 128'(sda), 128'(1));
        end
        scl = 1'b1;
        tick(Q);

        stb0 = stb_cnt;
        wbuf[0] = 8'h5A; wbuf[1] = 8'hC3;
        do_write(ADDR, 8'h03, 2, 1);
        chk("lit_addr_ack", 128'(last_addr_ack), 128'(1));
        chk("lit_reg3", 128'(user.regs_out[31:24]), 128'(8'h5A));
        chk("lit_reg4", 128'(user.regs_out[39:32]), 128'(8'hC3));
        chk("lit_stb_count", 128'(stb_cnt - stb0), 128'(2));
        chk("lit_wr_ptr_last", 128'(user.wr_ptr), 128'(4));

        wbuf[0] = 8'h96;
        do_write(ADDR, 8'h05, 1, 1);
        do_write(ADDR, 8'h02, 0, 0);
        do_read(ADDR, 3, 1);
        chk("lit_rd0", 128'(rbuf[0]), 128'(8'hAA));
        chk("lit_rd1", 128'(rbuf[1]), 128'(8'h5A));
        chk("lit_rd2", 128'(rbuf[2]), 128'(8'hC3));
        do_read(ADDR, 1, 1);
        chk("lit_ptr_after_read", 128'(rbuf[0]), 128'(8'h96));

        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        do_write(ADDR, 8'h0F, 2, 1);
        chk("lit_wrap_reg15", 128'(user.regs_out[127:120]), 128'(8'h11));
        chk("lit_wrap_reg0", 128'(user.regs_out[7:0]), 128'(8'h22));

        stb0 = stb_cnt;
        wbuf[0] = 8'h55;
        do_write(7'h42, 8'h20, 1, 1);
        chk("lit_bad_addr_nack", 128'(last_addr_ack), 128'(0));
        do_write(ADDR, 8'h20, 1, 1);
        chk("lit_bad_ptr_nack", 128'(last_ptr_ack), 128'(0));
        chk("lit_bad_ptr_data_nack", 128'(last_data_ack), 128'(0));
        chk("lit_no_stb", 128'(stb_cnt - stb0), 128'(0));

        stb0 = stb_cnt;
        do_write(ADDR, 8'h06, 0, 0);
        wbuf[0] = 8'h3F;
        for (int i = 7; i >= 4; i--) send_bit(wbuf[0][i]);
        tick(Q); m_low = 1'b0; tick(Q); scl = 1'b1; tick(Q);
        rst = 1'b1;
        #1;
        chk("rst_mid_sda", 128'(sda), 128'(1));
        chk("rst_mid_busy", 128'(user.busy), 128'(0));
        chk("rst_mid_regs", 128'(user.regs_out), all_init);
        m_ptr = 0;
        tick(3);
        rst = 1'b0;
        tick(Q);
        chk("rst_mid_no_stb", 128'(stb_cnt - stb0), 128'(0));
        do_write(ADDR, 8'h06, 1, 1);
        do_write(ADDR, 8'h06, 0, 0);
        do_read(ADDR, 1, 1);
        chk("lit_after_rst_rd", 128'(rbuf[0]), 128'(8'h3F));

        for (int t = 0; t < 16; t++) begin
            ra   = ($urandom_range(0, 5) == 0) ? 7'($urandom) : ADDR;
            rp   = 8'($urandom_range(0, NUM_REGS + 3));
            rn   = $urandom_range(0, 3);
            kind = $urandom_range(0, 2);
            for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
            case (kind)
                0: do_write(ra, rp, rn, 1);
                1: begin
                    do_write(ra, rp, rn, 0);
                    do_read(ADDR, $urandom_range(1, 3), 1);
                end
                default: do_read(ra, $urandom_range(1, 3), 1);
            endcase
        end

        tick(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
